// File: rtl/pipe_add_pkg.sv
// Shared constants and per-stage control record for pipe_add.
// Optional subtract mode is enabled by defining PIPE_ADD_SUB_EN.
package pipe_add_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;

   // Width-independent part of a stage; partial sum and pending
   // operand slices are WIDTH-sized and live beside it in the top.
   typedef struct packed {
      logic vld;
      logic cy;
      logic ov;
   } stage_t;

   function automatic int num_stages(input int width, input int slice);
      return width / slice;
   endfunction

endpackage

// File: rtl/pipe_add_slice.sv
// One SLICE-bit ripple adder, instantiated once per pipeline stage.
// Also reports the carry into its MSB for overflow detection.
module add_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             ci_i,
   output logic [SLICE-1:0] s_o,
   output logic             co_o,
   output logic             cm_o
);

   logic [SLICE:0] t;

   assign t    = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, ci_i};
   assign s_o  = t[SLICE-1:0];
   assign co_o = t[SLICE];
   assign cm_o = a_i[SLICE-1] ^ b_i[SLICE-1] ^ s_o[SLICE-1];

endmodule

// File: rtl/pipe_add.sv
// Carry-pipelined adder, one SLICE per stage, valid/ready at both ends.
// Define PIPE_ADD_SUB_EN to add the 'sub' port (a + ~b + 1).
module pipe_add
   import pipe_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef PIPE_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int STAGES = num_stages(WIDTH, SLICE);
   localparam int PW     = (STAGES > 1) ? WIDTH - SLICE : 1;

   logic [WIDTH-1:0] b_eff;
   logic             ci_eff;

`ifdef PIPE_ADD_SUB_EN
   assign b_eff  = sub ? ~b : b;
   assign ci_eff = sub | ci;
`else
   assign b_eff  = b;
   assign ci_eff = ci;
`endif

   stage_t           ctl_q [STAGES];
   stage_t           ctl_d [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic [WIDTH-1:0] s_d   [STAGES];
   logic [WIDTH-1:0] s_in  [STAGES];

   logic [STAGES-1:0] ld;
   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] cin;
   logic [STAGES-1:0] sl_co;
   logic [STAGES-1:0] sl_cm;

   logic [STAGES-1:0][SLICE-1:0] op_a;
   logic [STAGES-1:0][SLICE-1:0] op_b;
   logic [STAGES-1:0][SLICE-1:0] sl_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      if (k == 0) begin : g_first
         assign v_in[k] = in_valid;
         assign cin[k]  = ci_eff;
         assign s_in[k] = '0;
         assign op_a[k] = a[SLICE-1:0];
         assign op_b[k] = b_eff[SLICE-1:0];
      end else begin : g_next
         assign v_in[k] = ctl_q[k-1].vld;
         assign cin[k]  = ctl_q[k-1].cy;
         assign s_in[k] = s_q[k-1];
      end

      add_slice #(
         .SLICE(SLICE)
      ) u_slice (
         .a_i (op_a[k]),
         .b_i (op_b[k]),
         .ci_i(cin[k]),
         .s_o (sl_s[k]),
         .co_o(sl_co[k]),
         .cm_o(sl_cm[k])
      );
   end

   // Operand slices not yet added travel down, next slice kept at bit 0.
   if (STAGES > 1) begin : g_pend
      logic [PW-1:0] pa_q [STAGES-1];
      logic [PW-1:0] pb_q [STAGES-1];
      logic [PW-1:0] pa_d [STAGES-1];
      logic [PW-1:0] pb_d [STAGES-1];

      always_comb begin
         pa_d[0] = pa_q[0];
         pb_d[0] = pb_q[0];
         if (ld[0] && in_valid) begin
            pa_d[0] = a[WIDTH-1:SLICE];
            pb_d[0] = b_eff[WIDTH-1:SLICE];
         end
         for (int k = 1; k < STAGES - 1; k++) begin
            pa_d[k] = pa_q[k];
            pb_d[k] = pb_q[k];
            if (ld[k] && v_in[k]) begin
               pa_d[k] = pa_q[k-1] >> SLICE;
               pb_d[k] = pb_q[k-1] >> SLICE;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < STAGES - 1; k++) begin
               pa_q[k] <= '0;
               pb_q[k] <= '0;
            end
         end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
               pa_q[k] <= pa_d[k];
               pb_q[k] <= pb_d[k];
            end
         end
      end

      for (genvar k = 1; k < STAGES; k++) begin : g_op
         assign op_a[k] = pa_q[k-1][SLICE-1:0];
         assign op_b[k] = pb_q[k-1][SLICE-1:0];
      end
   end

   // Stage k may load when empty or when its occupant moves on.
   always_comb begin
      logic rdy;
      rdy = out_ready;
      ld  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ld[k] = !ctl_q[k].vld || rdy;
         rdy   = ld[k];
      end
   end

   // Finished slices enter at the top and shift down toward bit 0.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ctl_d[k] = ctl_q[k];
         s_d[k]   = s_q[k];
         if (ld[k]) begin
            ctl_d[k].vld = v_in[k];
            if (v_in[k]) begin
               ctl_d[k].cy = sl_co[k];
               ctl_d[k].ov = sl_co[k] ^ sl_cm[k];
               s_d[k]      = (s_in[k] >> SLICE)
                           | (WIDTH'(sl_s[k]) << (WIDTH - SLICE));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_q[k] <= '0;
            s_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_q[k] <= ctl_d[k];
            s_q[k]   <= s_d[k];
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = ctl_q[STAGES-1].vld;
   assign sum       = s_q[STAGES-1];
   assign co        = ctl_q[STAGES-1].cy;
   assign ovf       = ctl_q[STAGES-1].ov;

endmodule

// File: tb/tb_pipe_add.sv
// Directed bench for pipe_add at WIDTH=16, SLICE=4 (four stages).
// Subtract vectors run only when PIPE_ADD_SUB_EN is defined.
module tb_pipe_add;

   localparam int W  = 16;
   localparam int SL = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ci = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         co;
   logic         ovf;
`ifdef PIPE_ADD_SUB_EN
   logic         sub = 1'b0;
`endif

   pipe_add #(
      .WIDTH(W),
      .SLICE(SL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ci       (ci),
`ifdef PIPE_ADD_SUB_EN
      .sub      (sub),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .co       (co),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   function automatic logic [17:0] model(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic c);
      logic [16:0] t;
      logic        v;
      t = {1'b0, x} + {1'b0, y} + {16'b0, c};
      v = (x[15] == y[15]) && (t[15] != x[15]);
      return {t[16], v, t[15:0]};
   endfunction

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t tv [8];

   task automatic run_vec(input logic [15:0] va, input logic [15:0] vb,
                          input logic vci, output logic [17:0] res,
                          output int lat);
      @(posedge clk);
      #1;
      a = va;
      b = vb;
      ci = vci;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = {co, ovf, sum};
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [17:0] r;
      logic [17:0] res [8];
      logic [15:0] bp_a [4];
      logic [15:0] bp_b [4];
      logic        bp_c [4];
      int lat, got, first, last, acc, stale;

      tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tv[1] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
      tv[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      tv[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tv[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tv[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      tv[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};

      bp_a = '{16'h7FFF, 16'hA5A5, 16'h0001, 16'h8000};
      bp_b = '{16'h0001, 16'h5A5A, 16'hFFFF, 16'hFFFF};
      bp_c = '{1'b0, 1'b1, 1'b0, 1'b1};

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_vec(tv[i].a, tv[i].b, tv[i].ci, r, lat);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
         chk($sformatf("vec%0d_res", i), 32'(r),
             32'({tv[i].co, tv[i].ov, tv[i].s}));
      end

      // back-to-back stream
      @(posedge clk);
      #1;
      a = tv[0].a;
      b = tv[0].b;
      ci = tv[0].ci;
      in_valid = 1'b1;
      got = 0;
      first = 0;
      last = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            if (got == 0) first = c;
            if (got < 8) res[got] = {co, ovf, sum};
            got++;
            last = c;
         end
         if (c < 8) begin
            a = tv[c].a;
            b = tv[c].b;
            ci = tv[c].ci;
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("b2b_count", 32'(got), 32'd8);
      chk("b2b_first", 32'(first), 32'd4);
      chk("b2b_last", 32'(last), 32'd11);
      for (int i = 0; i < 8 && i < got; i++)
         chk($sformatf("b2b_res%0d", i), 32'(res[i]),
             32'({tv[i].co, tv[i].ov, tv[i].s}));

      // stall the consumer with the producer pushing
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         a = bp_a[acc & 3];
         b = bp_b[acc & 3];
         ci = bp_c[acc & 3];
         in_valid = 1'b1;
         #1;
         if (in_ready) acc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #1;
      chk("bp_accepted", 32'(acc), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({co, ovf, sum}),
          32'(model(bp_a[0], bp_b[0], bp_c[0])));
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) begin
            if (got < 4)
               chk($sformatf("bp_drain%0d", got), 32'({co, ovf, sum}),
                   32'(model(bp_a[got], bp_b[got], bp_c[got])));
            got++;
         end
         @(posedge clk);
         #2;
      end
      chk("bp_drain_count", 32'(got), 32'd4);

      // reset with three transactions in flight
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = tv[i].a;
         b = tv[i].b;
         ci = tv[i].ci;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 32'(out_valid), 32'd0);
      chk("rst_async_sum", 32'(sum), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("post_rst_stale", 32'(stale), 32'd0);
      run_vec(16'h00FF, 16'h0F01, 1'b0, r, lat);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_res", 32'(r), 32'({1'b0, 1'b0, 16'h1000}));

`ifdef PIPE_ADD_SUB_EN
      sub = 1'b1;
      run_vec(16'h0005, 16'h0007, 1'b0, r, lat);
      chk("sub_5m7_sum", 32'(r[15:0]), 32'h0000FFFE);
      chk("sub_5m7_co", 32'(r[17]), 32'd0);
      run_vec(16'h0007, 16'h0005, 1'b0, r, lat);
      chk("sub_7m5_sum", 32'(r[15:0]), 32'h00000002);
      chk("sub_7m5_co", 32'(r[17]), 32'd1);
      sub = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
